fp_pre_normalizer: RTL
======================

FP_PRE_NORMALIZER -- requirements
Module: fp_pre_normalizer

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Ports (name  direction  width  meaning):
 clk  in  1  clock, rising edge active
 rst  in  1  asynchronous active-low reset
 start_i  in  1  request; accepted on an edge where start_i=1 and ready_o=1
 op_i  in  1  0 = square root, 1 = inverse square root; sampled at accept
 x_i  in  16  signed two's-complement Q8.8 operand; sampled at accept
 valid_i  in  1  completion from the downstream SQRT_Floating_Point unit (its valid_o)
 ready_o  out  1  high only in IDLE
 DoSqrt_o  out  1  single-cycle start to downstream DoSqrt_i
 DoInvSqrt_o  out  1  single-cycle start to downstream DoInvSqrt_i
 s_o  out  1  sign of operand
 m_o  out  8  unsigned Q1.7 mantissa, m_o[7]=1 when nonzero
 e_o  out  8  signed exponent; |x| ~= m_o * 2^e_o
 zero_o  out  1  single-cycle pulse: operand was zero, nothing issued

Function
REQ-003 States: IDLE, ABS, SHIFT, ROUND, ISSUE, WAIT.
REQ-004 IDLE: on accept edge, register x_i and op_i, clear shift count k, go to ABS.
REQ-005 ABS: register s = x[15]; mag = |x| as 16-bit unsigned (0x8000 -> 0x8000); go to SHIFT.
REQ-006 SHIFT, per edge: mag==0 -> pulse zero_o, set m_o=0x00, e_o=0, s_o=s, go to IDLE; else mag[15]=1 -> go to ROUND; else mag <<= 1, k += 1 (k max 15).
REQ-007 ROUND: m = mag[15:8] + mag[7] (round half up), e = 7 - k; if mag[15:8]=0xFF and mag[7]=1 then m=0x80, e=8-k; register m_o, e_o, s_o; go to ISSUE.
REQ-008 e_o range -8..+8; 4-bit k and sign extension to 8 bits; no overflow possible.
REQ-009 ISSUE: exactly one cycle; DoSqrt_o=1 if op=0 else DoInvSqrt_o=1; go to WAIT.
REQ-010 DoSqrt_o and DoInvSqrt_o never both high; each high only in ISSUE.
REQ-011 Latency: Do*_o high in the cycle after the (k+3)th rising edge following the accept edge; zero_o high in the cycle after the 2nd edge.
REQ-012 WAIT: stay until valid_i=1, then go to IDLE on that edge; ready_o rises the following cycle.
REQ-013 m_o, e_o, s_o held stable from ROUND until the next ROUND or zero result; downstream may sample at any time through WAIT.
REQ-014 start_i while ready_o=0 ignored, no queuing; x_i/op_i changes after accept have no effect.
REQ-015 valid_i outside WAIT ignored; valid_i in the same cycle as ISSUE not honoured (WAIT entered first).
REQ-016 No timeout in WAIT; block stays busy until valid_i or reset.

Reset
REQ-017 rst=0 SHALL immediately force state IDLE, ready_o=1, DoSqrt_o=0, DoInvSqrt_o=0, zero_o=0, s_o=0, m_o=0x00, e_o=0x00, k=0, regardless of state.
REQ-018 Operation aborted by reset SHALL produce no Do*_o pulse after rst returns high; first accept possible on first edge with rst=1.

Verification
REQ-019 x_i=0x0100, op_i=0 -> k=7, m_o=0x80, e_o=0x00, s_o=0, DoSqrt_o one cycle after 10th edge, ready_o=1 the cycle after valid_i.
REQ-020 x_i=0xFE80 (-1.5), op_i=1 -> m_o=0xC0, e_o=0x00, s_o=1, DoInvSqrt_o single pulse, DoSqrt_o stays 0.
REQ-021 x_i=0x7FFF -> rounding carry: m_o=0x80, e_o=0x07; x_i=0x8000 -> m_o=0x80, e_o=0x07, s_o=1.
REQ-022 x_i=0x0001 -> k=15, m_o=0x80, e_o=0xF8 (-8), Do pulse after 18th edge; x_i=0x0000 -> zero_o one cycle, no Do pulse, ready_o back high.
REQ-023 start_i held high through busy period and spurious valid_i during SHIFT -> exactly one issue, no early return to IDLE.
REQ-024 rst driven low mid-SHIFT between edges -> outputs reach reset values without a clock edge; no Do pulse after release.

Source files
------------

// File: rtl/fp_pre_normalizer.sv
// Converts a signed Q8.8 operand into sign / Q1.7 mantissa / exponent form and
// issues a single-cycle sqrt or inverse-sqrt start to the downstream unit.
module fp_pre_normalizer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        op_i,
   input  logic [15:0] x_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic        DoSqrt_o,
   output logic        DoInvSqrt_o,
   output logic        s_o,
   output logic [7:0]  m_o,
   output logic [7:0]  e_o,
   output logic        zero_o
);

   localparam int unsigned XW = 16;
   localparam int unsigned MW = 8;
   localparam int unsigned KW = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_ABS, S_SHIFT, S_ROUND, S_ISSUE, S_WAIT
   } state_t;

   state_t          r_state;
   logic [XW-1:0]   r_x;
   logic            r_op;
   logic            r_sign;
   logic [XW-1:0]   r_mag;
   logic [KW-1:0]   r_k;
   logic            r_ready;
   logic            r_do_sqrt;
   logic            r_do_inv;
   logic            r_zero;
   logic            r_s_o;
   logic [MW-1:0]   r_m_o;
   logic [MW-1:0]   r_e_o;

   logic [XW-1:0]   w_abs;
   logic            w_carry;
   logic [MW-1:0]   w_m;
   logic [MW-1:0]   w_e;

   // 0x8000 negates to itself, which is the correct unsigned magnitude
   assign w_abs   = r_x[XW-1] ? XW'(~r_x + XW'(1)) : r_x;

   // round half up; an all-ones mantissa carries out into the exponent
   assign w_carry = &r_mag[XW-1:7];
   assign w_m     = w_carry ? MW'(8'h80) : MW'(r_mag[XW-1:8] + MW'(r_mag[7]));
   assign w_e     = w_carry ? MW'(MW'(8) - MW'(r_k)) : MW'(MW'(7) - MW'(r_k));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_x       <= '0;
         r_op      <= 1'b0;
         r_sign    <= 1'b0;
         r_mag     <= '0;
         r_k       <= '0;
         r_ready   <= 1'b1;
         r_do_sqrt <= 1'b0;
         r_do_inv  <= 1'b0;
         r_zero    <= 1'b0;
         r_s_o     <= 1'b0;
         r_m_o     <= '0;
         r_e_o     <= '0;
      end else begin
         r_do_sqrt <= 1'b0;
         r_do_inv  <= 1'b0;
         r_zero    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_x     <= x_i;
                  r_op    <= op_i;
                  r_k     <= '0;
                  r_ready <= 1'b0;
                  r_state <= S_ABS;
               end
            end
            S_ABS: begin
               r_sign  <= r_x[XW-1];
               r_mag   <= w_abs;
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               if (r_mag == '0) begin
                  r_zero  <= 1'b1;
                  r_m_o   <= '0;
                  r_e_o   <= '0;
                  r_s_o   <= r_sign;
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end else if (r_mag[XW-1]) begin
                  r_state <= S_ROUND;
               end else begin
                  r_mag <= {r_mag[XW-2:0], 1'b0};
                  r_k   <= r_k + KW'(1);
               end
            end
            S_ROUND: begin
               r_m_o     <= w_m;
               r_e_o     <= w_e;
               r_s_o     <= r_sign;
               r_do_sqrt <= ~r_op;
               r_do_inv  <= r_op;
               r_state   <= S_ISSUE;
            end
            S_ISSUE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (valid_i) begin
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready_o     = r_ready;
   assign DoSqrt_o    = r_do_sqrt;
   assign DoInvSqrt_o = r_do_inv;
   assign zero_o      = r_zero;
   assign s_o         = r_s_o;
   assign m_o         = r_m_o;
   assign e_o         = r_e_o;

endmodule
